// File: rtl/fetch32_if.sv
// Fetch-stage bus bundle: memory read port, instruction handoff to the core, and redirect input.
// master = fetch32 side; slave = memory/core side.
interface fetch32_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        op_valid;
    logic [31:0] op;
    logic [31:0] op_pc;
    logic        op_ready;
    logic        redir;
    logic [31:0] redir_pc;

    modport master (
        output mem_req, mem_addr, op_valid, op, op_pc,
        input  mem_ack, mem_rdata, op_ready, redir, redir_pc
    );

    modport slave (
        input  mem_req, mem_addr, op_valid, op, op_pc,
        output mem_ack, mem_rdata, op_ready, redir, redir_pc
    );
endinterface

// File: rtl/fetch32.sv
// Sequential instruction fetch into a QDEPTH-entry prefetch queue; transfer to op_valid is 1 cycle.
// Core backpressure fills the queue and then fetching stalls; redirect flushes and drops any in-flight read.
module fetch32 #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic       clk,
    input logic       reset,
    fetch32_if.master bus
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] dat;
    } entry_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          op_valid_q, op_valid_d;
    entry_t        op_q, op_d;
    entry_t        queue_q [QDEPTH];

    logic   mem_req;
    logic   xfer;
    logic   push;
    logic   pop;
    entry_t push_ent;

    assign mem_req  = (state_q != IDLE);
    assign xfer     = mem_req && bus.mem_ack;
    assign push     = (state_q == FETCH) && xfer && !bus.redir;
    assign pop      = op_valid_q && bus.op_ready && !bus.redir;
    assign push_ent = '{pc: addr_q, dat: bus.mem_rdata};

    // addr_q is latched at request issue so a redirect cannot disturb an in-flight address.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: begin
                if (!bus.redir && count_q < CW'(QDEPTH)) begin
                    state_d = FETCH;
                    addr_d  = pc_q;
                end
            end
            FETCH: begin
                if (xfer)
                    state_d = IDLE;
                else if (bus.redir)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (xfer)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (push)
            pc_d = pc_q + 32'd4;
        if (bus.redir)
            pc_d = bus.redir_pc & 32'hFFFF_FFFC;
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        op_d    = op_q;
        if (bus.redir) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push)
                tail_d = tail_q + PW'(1);
            if (pop)
                head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        op_valid_d = (count_d != '0);
        // A push into a queue that is empty after this cycle's pop must bypass storage.
        if (op_valid_d)
            op_d = (push && count_q == CW'(pop)) ? push_ent : queue_q[head_d];
    end

    always_ff @(posedge clk) begin
        if (push)
            queue_q[tail_q] <= push_ent;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            addr_q     <= RESET_PC;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            op_valid_q <= 1'b0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            op_valid_q <= op_valid_d;
            op_q       <= op_d;
        end
    end

    assign bus.mem_req  = mem_req;
    assign bus.mem_addr = addr_q;
    assign bus.op_valid = op_valid_q;
    assign bus.op       = op_q.dat;
    assign bus.op_pc    = op_q.pc;
endmodule

// File: tb/tb_fetch32.sv
// Directed bench for fetch32: memory responder with programmable ack delay, inputs driven and outputs
// sampled on the falling edge, expected values written out by hand.
module tb_fetch32;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   ack_delay;
    int   wait_cnt;
    int   xfer_cnt;
    int   n;

    fetch32_if bif ();

    fetch32 #(.QDEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: ack arrives once a request has been visible for more than ack_delay falling edges.
    always @(negedge clk) begin
        if (reset || !bif.mem_req) begin
            wait_cnt    = 0;
            bif.mem_ack = 1'b0;
        end else begin
            wait_cnt      = wait_cnt + 1;
            bif.mem_ack   = (wait_cnt > ack_delay);
            bif.mem_rdata = bif.mem_addr ^ 32'hA5A5_A5A5;
        end
    end

    always @(posedge clk) begin
        if (reset)
            xfer_cnt = 0;
        else if (bif.mem_req && bif.mem_ack)
            xfer_cnt = xfer_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bif.op_valid && cyc < max);
        n_checks++;
        assert (bif.op_valid === 1'b1)
        else begin
            n_fail++;
            $error("FAIL wait_valid: op_valid still %b after %0d cycles, expected 1", bif.op_valid, cyc);
        end
    endtask

    task automatic wait_xfers(input int target);
        int cyc;
        cyc = 0;
        while (xfer_cnt < target && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("xfer_count_reached", 32'(xfer_cnt), 32'(target));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        ack_delay    = 1;
        reset        = 1'b0;
        bif.op_ready = 1'b0;
        bif.redir    = 1'b0;
        bif.redir_pc = 32'h0;
        #1 reset = 1'b1;
        step(2);

        chk("rst_mem_req",  32'(bif.mem_req),  32'h0);
        chk("rst_mem_addr", bif.mem_addr,      32'h0);
        chk("rst_op_valid", 32'(bif.op_valid), 32'h0);
        chk("rst_op",       bif.op,            32'h0);
        chk("rst_op_pc",    bif.op_pc,         32'h0);

        // Streaming with the core always ready.
        bif.op_ready = 1'b1;
        reset        = 1'b0;
        wait_valid(10, n);
        chk("first_latency", 32'(n), 32'd3);
        chk("s_pc0", bif.op_pc, 32'h0000_0000);
        chk("s_op0", bif.op,    32'hA5A5_A5A5);
        wait_valid(10, n);
        chk("s_pc1", bif.op_pc, 32'h0000_0004);
        chk("s_op1", bif.op,    32'hA5A5_A5A1);
        wait_valid(10, n);
        chk("s_pc2", bif.op_pc, 32'h0000_0008);
        chk("s_op2", bif.op,    32'hA5A5_A5AD);
        wait_valid(10, n);
        chk("s_pc3", bif.op_pc, 32'h0000_000C);
        chk("s_op3", bif.op,    32'hA5A5_A5A9);

        // Core stalled: queue fills to 4 and fetch stops.
        bif.op_ready = 1'b0;
        do_reset();
        step(30);
        chk("full_xfers",    32'(xfer_cnt),     32'd4);
        chk("full_mem_req",  32'(bif.mem_req),  32'h0);
        chk("full_op_valid", 32'(bif.op_valid), 32'h1);
        chk("full_head_pc",  bif.op_pc,         32'h0000_0000);
        bif.op_ready = 1'b1;
        step(1);
        chk("drain_pc4", bif.op_pc, 32'h0000_0004);
        step(1);
        chk("drain_pc8",     bif.op_pc,        32'h0000_0008);
        chk("resume_req",    32'(bif.mem_req), 32'h1);
        chk("resume_addr",   bif.mem_addr,     32'h0000_0010);
        step(1);
        chk("drain_pcC", bif.op_pc, 32'h0000_000C);
        step(1);
        chk("bypass_valid", 32'(bif.op_valid), 32'h1);
        chk("bypass_pc",    bif.op_pc,         32'h0000_0010);
        chk("bypass_op",    bif.op,            32'hA5A5_A5B5);
        bif.op_ready = 1'b0;

        // Redirect while a slow read is in flight with two entries queued.
        do_reset();
        wait_xfers(2);
        ack_delay = 3;
        step(1);
        chk("r_req_pending", 32'(bif.mem_req), 32'h1);
        chk("r_addr_before", bif.mem_addr,     32'h0000_0008);
        bif.redir    = 1'b1;
        bif.redir_pc = 32'h0000_1003;
        step(1);
        bif.redir = 1'b0;
        chk("r_flush_valid", 32'(bif.op_valid), 32'h0);
        chk("r_addr_hold1",  bif.mem_addr,      32'h0000_0008);
        step(1);
        chk("r_req_hold",    32'(bif.mem_req), 32'h1);
        chk("r_addr_hold2",  bif.mem_addr,     32'h0000_0008);
        step(2);
        chk("r_dropped_valid", 32'(bif.op_valid), 32'h0);
        chk("r_idle_req",      32'(bif.mem_req),  32'h0);
        ack_delay = 1;
        step(1);
        chk("r_new_req",  32'(bif.mem_req), 32'h1);
        chk("r_new_addr", bif.mem_addr,     32'h0000_1000);
        step(2);
        chk("r_first_valid", 32'(bif.op_valid), 32'h1);
        chk("r_first_pc",    bif.op_pc,         32'h0000_1000);
        chk("r_first_op",    bif.op,            32'hA5A5_B5A5);

        // Redirect coinciding with a transfer and a pop.
        step(1);
        chk("c_req",  32'(bif.mem_req), 32'h1);
        chk("c_addr", bif.mem_addr,     32'h0000_1004);
        step(1);
        bif.op_ready = 1'b1;
        bif.redir    = 1'b1;
        bif.redir_pc = 32'h0000_2000;
        step(1);
        bif.redir    = 1'b0;
        bif.op_ready = 1'b0;
        chk("c_empty_valid", 32'(bif.op_valid), 32'h0);
        chk("c_idle_req",    32'(bif.mem_req),  32'h0);
        step(1);
        chk("c_next_req",  32'(bif.mem_req), 32'h1);
        chk("c_next_addr", bif.mem_addr,     32'h0000_2000);
        step(2);
        chk("c_pc", bif.op_pc, 32'h0000_2000);
        chk("c_op", bif.op,    32'hA5A5_85A5);

        // Address wrap at the top of memory.
        bif.op_ready = 1'b1;
        bif.redir    = 1'b1;
        bif.redir_pc = 32'hFFFF_FFF8;
        step(1);
        bif.redir = 1'b0;
        chk("w_flush_valid", 32'(bif.op_valid), 32'h0);
        wait_valid(10, n);
        chk("w_pc0", bif.op_pc, 32'hFFFF_FFF8);
        chk("w_op0", bif.op,    32'h5A5A_5A5D);
        wait_valid(10, n);
        chk("w_pc1", bif.op_pc, 32'hFFFF_FFFC);
        chk("w_op1", bif.op,    32'h5A5A_5A59);
        wait_valid(10, n);
        chk("w_pc2", bif.op_pc, 32'h0000_0000);
        chk("w_op2", bif.op,    32'hA5A5_A5A5);

        // Asynchronous reset with three entries queued and a read outstanding.
        bif.op_ready = 1'b0;
        do_reset();
        wait_xfers(3);
        step(1);
        chk("a_pre_req",   32'(bif.mem_req),  32'h1);
        chk("a_pre_addr",  bif.mem_addr,      32'h0000_000C);
        chk("a_pre_valid", 32'(bif.op_valid), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("a_rst_req",   32'(bif.mem_req),  32'h0);
        chk("a_rst_valid", 32'(bif.op_valid), 32'h0);
        chk("a_rst_addr",  bif.mem_addr,      32'h0000_0000);
        chk("a_rst_pc",    bif.op_pc,         32'h0000_0000);
        @(negedge clk);
        reset        = 1'b0;
        bif.op_ready = 1'b1;
        step(1);
        chk("a_restart_req",  32'(bif.mem_req), 32'h1);
        chk("a_restart_addr", bif.mem_addr,     32'h0000_0000);
        wait_valid(10, n);
        chk("a_restart_pc", bif.op_pc, 32'h0000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d assertions evaluated", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
